// File: rtl/tcdm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_port_arbiter
// Purpose  : Round-robin arbiter sharing one TCDM target port between
//            NUM_PORTS initiators. A decision is locked until the target
//            grants it, the winner's index is queued in an in-order ID FIFO,
//            and each response beat is steered back to the FIFO head.
// Ports    : clk_i/rst_i        clock, asynchronous active-high reset
//            slv_*              per-initiator request/grant/response (packed)
//            mst_*              shared target request/grant/response
//            err_o              sticky flag: response beat with no ID queued
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS-1:0]             slv_req_i,
    output logic [NUM_PORTS-1:0]             slv_gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  slv_addr_i,
    input  logic [NUM_PORTS-1:0]             slv_wen_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] slv_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  slv_data_i,
    input  logic [NUM_PORTS-1:0]             slv_r_ready_i,
    output logic [NUM_PORTS-1:0]             slv_r_valid_o,
    output logic [DATA_WIDTH-1:0]            slv_r_data_o,
    output logic                             mst_req_o,
    input  logic                             mst_gnt_i,
    output logic [ADDR_WIDTH-1:0]            mst_addr_o,
    output logic                             mst_wen_o,
    output logic [DATA_WIDTH/8-1:0]          mst_be_o,
    output logic [DATA_WIDTH-1:0]            mst_data_o,
    input  logic                             mst_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            mst_r_data_i,
    output logic                             mst_r_ready_o,
    output logic                             err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int C_ID_W   = $clog2(NUM_PORTS);
    localparam int C_PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int C_CNT_W  = $clog2(MAX_OUTST + 1);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [C_ID_W-1:0]         sel_q, sel_d;
    logic [C_ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [C_PTR_W-1:0]        wptr_q, wptr_d;
    logic [C_PTR_W-1:0]        rptr_q, rptr_d;
    logic [C_CNT_W-1:0]        count_q, count_d;
    logic                      err_q, err_d;
    logic [C_ID_W-1:0]         mem_q [MAX_OUTST];
    logic [C_ID_W-1:0]         mem_d [MAX_OUTST];

    logic [C_ID_W-1:0]         winner;
    logic [C_ID_W-1:0]         sel;
    logic [C_ID_W-1:0]         head;
    logic                      fifo_full, fifo_empty;
    logic                      req_any, fire, pop;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan: first requester at or after rr_ptr, wrapping.
    always_comb begin
        logic found;
        winner = rr_ptr_q;
        found  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int j;
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && slv_req_i[j]) begin
                winner = C_ID_W'(j);
                found  = 1'b1;
            end
        end
    end

    assign fifo_full  = (count_q == C_CNT_W'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rptr_q];

    // Once locked, the held winner is the only request that matters.
    assign sel     = (state_q == LOCK) ? sel_q : winner;
    assign req_any = (state_q == LOCK) ? slv_req_i[sel_q] : |slv_req_i;

    always_comb begin
        mst_req_o     = 1'b0;
        slv_gnt_o     = '0;
        mst_addr_o    = '0;
        mst_wen_o     = 1'b0;
        mst_be_o      = '0;
        mst_data_o    = '0;
        slv_r_valid_o = '0;
        mst_r_ready_o = 1'b0;
        slv_r_data_o  = '0;
        fire          = 1'b0;
        pop           = 1'b0;
        if (!rst_i) begin
            mst_req_o  = req_any && !fifo_full;
            fire       = mst_req_o && mst_gnt_i;
            if (fire) slv_gnt_o[sel] = 1'b1;
            mst_addr_o = slv_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            mst_wen_o  = slv_wen_i[sel];
            mst_be_o   = slv_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
            mst_data_o = slv_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            // A beat with no queued ID is dropped: no valid, no ready.
            if (!fifo_empty) begin
                slv_r_valid_o[head] = mst_r_valid_i;
                mst_r_ready_o       = slv_r_ready_i[head];
            end
            slv_r_data_o = mst_r_data_i;
            pop          = mst_r_valid_i && mst_r_ready_o;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        err_d    = err_q | (mst_r_valid_i && fifo_empty);

        case (state_q)
            ARB: begin
                if (mst_req_o && !mst_gnt_i) begin
                    state_d = LOCK;
                    sel_d   = winner;
                end
            end
            LOCK: begin
                if (mst_gnt_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        if (fire) begin
            rr_ptr_d      = (sel == C_ID_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
            mem_d[wptr_q] = sel;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);

        // Simultaneous push and pop leave the count unchanged.
        if (fire && !pop)      count_d = count_q + 1'b1;
        else if (!fire && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < MAX_OUTST; k++) mem_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

    assign err_o = err_q;

endmodule
`default_nettype wire
